// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute-stage ALU with valid/ready handshake; iterative shifter by default, single-cycle barrel shifter when ALU_FAST_SHIFT_EN is defined
module alu_exec_stage #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;

  logic             out_valid_q, out_valid_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] res;
  logic             accept;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0] op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0111: return {{(WIDTH-1){1'b0}}, $signed(x) < $signed(y)};
      4'b1000: return x ^ y;
      4'b1100: return ~(x | y);
      OP_SLL:  return x << y[SHAMT_W-1:0];
      OP_SRL:  return x >> y[SHAMT_W-1:0];
      OP_SRA:  return $signed(x) >>> y[SHAMT_W-1:0];
      default: return '0;
    endcase
  endfunction

  assign res       = alu_fn(alu_ctl, a, b);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

`ifdef ALU_FAST_SHIFT_EN
  assign in_ready = !out_valid_q || out_ready;
  assign busy     = 1'b0;
  // Every op, shifts included, loads at the accept edge; otherwise the output slot drains
  always_comb begin
    out_valid_d = accept || (out_valid_q && !out_ready);
    result_d    = accept ? res : result_q;
    zero_d      = accept ? res == '0 : zero_q;
  end
`else
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d, step;
  logic [SHAMT_W-1:0] cnt_q, cnt_d, shamt;
  logic [3:0]         op_q, op_d;
  logic               is_shift, start, done;

  assign shamt    = b[SHAMT_W-1:0];
  assign is_shift = alu_ctl inside {OP_SLL, OP_SRL, OP_SRA};
  assign start    = accept && is_shift && shamt != '0;
  assign done     = state_q == SHIFT && cnt_q == SHAMT_W'(1);
  assign step     = alu_fn(op_q, shreg_q, WIDTH'(1));
  assign in_ready = state_q == IDLE && (!out_valid_q || out_ready);
  assign busy     = state_q == SHIFT;

  // Nonzero shifts walk one bit per cycle; everything else loads at the accept edge
  always_comb begin
    state_d     = start ? SHIFT : done ? IDLE : state_q;
    shreg_d     = start ? a : state_q == SHIFT ? step : shreg_q;
    cnt_d       = start ? shamt : state_q == SHIFT ? cnt_q - SHAMT_W'(1) : cnt_q;
    op_d        = start ? alu_ctl : op_q;
    out_valid_d = (accept && !start) || done || (out_valid_q && !out_ready);
    result_d    = done ? step : accept && !start ? res : result_q;
    zero_d      = done ? step == '0 : accept && !start ? res == '0 : zero_q;
  end

  // Shift FSM registers; reset abandons any shift in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end
`endif

  // Output slot registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
    end
  end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage ALU. Consumes the 4-bit ALU control code from the ALU control decoder and two 32-bit operands, and produces a registered result and zero flag.
- Valid/ready handshake on both input and output sides.
- Logical and arithmetic ops complete in one cycle. Shifts run iteratively, one bit per cycle, under a small FSM.
- Sits between the register-read/decode stage and the memory/writeback stage.

Parameters:
- WIDTH, 32: operand and result width.
- SHAMT_W, 5: shift-amount width; taken from b[SHAMT_W-1:0].

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands and alu_ctl are valid
- in_ready  output  1  stage can accept an operation
- alu_ctl  input  4  ALU control code
- a  input  WIDTH  operand A (shift source)
- b  input  WIDTH  operand B (shift amount in low SHAMT_W bits)
- out_valid  output  1  result/zero valid
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  registered result
- zero  output  1  registered, high when result == 0
- busy  output  1  iterative shift in progress

Behaviour:
- Clock/reset: single clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, result=0, zero=0, busy=0.
- Reset mid-shift: aborts the operation; no result is produced.
- Codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1000 XOR, 1100 NOR.
  - 0011 SLL, 0100 SRL, 0101 SRA.
  - Any other code: result=0, zero=1, handled as single-cycle.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH; no overflow flag. SLT compares a and b as two's complement.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A combinational out_ready->in_ready path is permitted.
- Accept occurs at a rising edge where in_valid && in_ready.
- FSM states: IDLE, SHIFT.
  - IDLE, accept of a single-cycle op, or a shift with shamt==0: result, zero and out_valid=1 load at the accept edge. Latency 1. The next cycle is IDLE again, so back-to-back throughput is 1/cycle when out_ready=1.
  - IDLE, accept of a shift with shamt=n>0: shreg<=a, cnt<=n, op latched, go to SHIFT. busy=1 while in SHIFT.
  - SHIFT: each cycle, shreg shifts by 1 (SLL: zero fill; SRL: zero fill; SRA: sign fill) and cnt decrements. On the edge where cnt goes 1->0: result<=shifted value, zero updated, out_valid<=1, state->IDLE. Total latency n+1 edges from accept. in_ready=0 throughout SHIFT.
- Output hold:
  - While out_valid && !out_ready, result and zero are held stable and no new op is accepted.
  - On out_valid && out_ready, out_valid clears unless a new single-cycle result loads at the same edge, in which case it stays 1 with the new data.
- A SHIFT completion never collides with a pending result: SHIFT is only entered when the output slot is free or being drained.
- Inputs are sampled only at accept. Changes to a, b or alu_ctl during SHIFT have no effect.

Optional Feature:
- Macro: ALU_FAST_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter, latency 1 like every other op. The SHIFT state is not generated and busy is tied to 0.
- Undefined: the iterative shifter described above.
- Results are bit-identical in both builds; only latency and busy differ.

Test Plan:
- ADD a=5, b=7, alu_ctl=0010, out_ready=1 -> one edge after accept: out_valid=1, result=12, zero=0.
- SUB a=9, b=9 -> result=0, zero=1. SUB a=0, b=1 -> result=0xFFFFFFFF, zero=0.
- SRA a=0x80000000, b=4 -> busy=1 and in_ready=0 for 4 cycles; out_valid at accept+5 with result=0xF8000000. Under ALU_FAST_SHIFT_EN: same result at accept+1, busy never 1.
- Backpressure: ADD 1+1 accepted, out_ready=0 for 3 cycles with a second op (OR 0xF0|0x0F) offered -> result=2 held stable, in_ready=0. Raise out_ready -> second op accepted on that edge, next result=0xFF.
- Reset asserted 10 cycles into SLL a=1, b=31 -> after the edge: out_valid=0, busy=0, in_ready=1, result=0, and no late result ever appears.
- SLT a=0xFFFFFFFF, b=1 -> result=1. SLL a=0x1234, b=0 -> result=0x1234 at latency 1. alu_ctl=1111 -> result=0, zero=1.
